// File: rtl/io_responder.sv
// IO window peripheral: LED register, synchronised switches, 8N1 UART transmitter, reloading timer.
// Reads are combinational, writes commit on the clock edge; no backpressure, every access takes one cycle.
module io_responder #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int LED_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       io_addr,
  input  logic             io_wr,
  input  logic [31:0]      io_wdat,
  output logic [31:0]      rd_io_dat,
  input  logic [LED_W-1:0] sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             uart_tx,
  output logic             irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  logic wr_led, wr_tx, wr_stat, wr_tload, wr_tctrl;
  assign wr_led   = io_wr && (io_addr == 4'd0);
  assign wr_tx    = io_wr && (io_addr == 4'd2);
  assign wr_stat  = io_wr && (io_addr == 4'd3);
  assign wr_tload = io_wr && (io_addr == 4'd4);
  assign wr_tctrl = io_wr && (io_addr == 4'd5);

  logic [LED_W-1:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wr_led) led_out <= io_wdat[LED_W-1:0];
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  tx_state_t tx_state, tx_state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic          busy, bit_end, overrun;

  assign busy    = (tx_state != S_IDLE);
  assign bit_end = (clk_cnt == BIT_LAST);

  // uart_tx decodes straight from state so a reset forces the line idle at once.
  always_comb begin
    tx_state_nxt = tx_state;
    uart_tx      = 1'b1;
    case (tx_state)
      S_IDLE:  if (wr_tx) tx_state_nxt = S_START;
      S_START: begin
        uart_tx = 1'b0;
        if (bit_end) tx_state_nxt = S_DATA;
      end
      S_DATA: begin
        uart_tx = tx_byte[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) tx_state_nxt = S_STOP;
      end
      S_STOP:  if (bit_end) tx_state_nxt = S_IDLE;
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      overrun  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == S_IDLE) begin
        clk_cnt <= '0;
        bit_idx <= '0;
        if (wr_tx) tx_byte <= io_wdat[7:0];
      end else if (bit_end) begin
        clk_cnt <= '0;
        if (tx_state == S_DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
      if (wr_tx && busy)                overrun <= 1'b1;
      else if (wr_stat && io_wdat[1])   overrun <= 1'b0;
    end
  end

  logic [31:0] tload, counter;
  logic        t_en, pending, fire;

  assign fire = t_en && (counter == 32'd0);
  assign irq  = pending;

  // A TLOAD write overrides both decrement and reload in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tload   <= '0;
      counter <= '0;
      t_en    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_tload) begin
        tload   <= io_wdat;
        counter <= io_wdat;
      end else if (t_en) begin
        counter <= (counter != 32'd0) ? counter - 32'd1 : tload;
      end
      if (wr_tctrl) t_en <= io_wdat[0];
      if (fire)                          pending <= 1'b1;
      else if (wr_tctrl && io_wdat[1])   pending <= 1'b0;
    end
  end

  always_comb begin
    rd_io_dat = '0;
    case (io_addr)
      4'd0: rd_io_dat[LED_W-1:0] = led_out;
      4'd1: rd_io_dat[LED_W-1:0] = sw_sync;
      4'd3: rd_io_dat = {30'b0, overrun, busy};
      4'd4: rd_io_dat = tload;
      4'd5: rd_io_dat = {30'b0, pending, t_en};
      4'd6: rd_io_dat = counter;
      default: rd_io_dat = '0;
    endcase
  end

endmodule
